zfh_mult_sched: RTL and testbench



---
 rtl/fpu_types_pkg.sv | 20 ++
 rtl/zfh_mult_sched_arb.sv | 30 +++
 rtl/zfh_mult_sched.sv | 123 ++++++++++++
 tb/tb_zfh_mult_sched.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_types_pkg.sv
// Half-precision (Zfh) field widths plus the shared types used by the
// multiplier scheduler.
package fpu_types_pkg;

  localparam int unsigned HALF_EXPONENT_W = 5;
  localparam int unsigned HALF_FRACTION_W = 10;
  localparam int unsigned HALF_FLOAT_W    = 1 + HALF_EXPONENT_W + HALF_FRACTION_W;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } sched_state_t;

  typedef struct packed {
    logic [HALF_FLOAT_W-1:0] float1;
    logic [HALF_FLOAT_W-1:0] float2;
  } half_mult_req_t;

endpackage

// File: rtl/zfh_mult_sched_arb.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo NREQ.
module zfh_mult_sched_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] grant_id
);

  // Upper segment [ptr, NREQ) is searched first, then the wrap-around [0, ptr).
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && req[j] && (ID_W'(j) >= ptr)) begin
        found    = 1'b1;
        grant_id = ID_W'(j);
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        grant_id = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/zfh_mult_sched.sv
// Shares one external Zfh multiplier among NREQ requesters: round-robin grant,
// fixed-latency hold of registered operands, single response channel.
module zfh_mult_sched
  import fpu_types_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         flush,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*HALF_FLOAT_W-1:0] req_float1,
  input  logic [NREQ*HALF_FLOAT_W-1:0] req_float2,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [HALF_FLOAT_W-1:0]      rsp_product,
  output logic [HALF_FLOAT_W-1:0]      mult_float1,
  output logic [HALF_FLOAT_W-1:0]      mult_float2,
  input  logic [HALF_FLOAT_W-1:0]      mult_product,
  output logic                         busy,
  output logic [15:0]                  op_count
);

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  sched_state_t   state, state_next;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [CNT_W-1:0] cnt;
  half_mult_req_t   ops;
  half_mult_req_t   sel;
  logic             found;
  logic [ID_W-1:0]  grant_id;
  logic             grant_en;

  zfh_mult_sched_arb #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .found    (found),
    .grant_id (grant_id)
  );

  assign grant_en    = (state == IDLE) && !flush && found;
  assign mult_float1 = ops.float1;
  assign mult_float2 = ops.float2;

  always_comb begin
    sel = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (ID_W'(j) == grant_id) begin
        sel.float1 = req_float1[j*HALF_FLOAT_W +: HALF_FLOAT_W];
        sel.float2 = req_float2[j*HALF_FLOAT_W +: HALF_FLOAT_W];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (found) state_next = EXEC;
        EXEC:    if (cnt == '0) state_next = DONE;
        DONE:    if (rsp_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    rsp_valid = (state == DONE);
    req_ready = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      req_ready[j] = grant_en && (grant_id == ID_W'(j));
    end
  end

  // Flush drops the in-flight product and any pending count, but keeps rr_ptr.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr      <= '0;
      cur_id      <= '0;
      cnt         <= '0;
      ops         <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
      op_count    <= '0;
    end else begin
      if (grant_en) begin
        ops    <= sel;
        cur_id <= grant_id;
        rr_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        cnt    <= CNT_W'(MUL_LAT - 1);
      end
      if ((state == EXEC) && !flush) begin
        if (cnt == '0) begin
          rsp_product <= mult_product;
          rsp_id      <= cur_id;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
      if ((state == DONE) && rsp_ready && !flush) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_zfh_mult_sched.sv
// Directed bench for zfh_mult_sched with a lookup-table multiplier stub.
module tb_zfh_mult_sched;
  import fpu_types_pkg::*;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned MUL_LAT = 2;
  localparam int unsigned ID_W    = 1;

  logic                         CLK = 1'b0;
  logic                         nRST;
  logic                         flush;
  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ*HALF_FLOAT_W-1:0] req_float1;
  logic [NREQ*HALF_FLOAT_W-1:0] req_float2;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic [HALF_FLOAT_W-1:0]      rsp_product;
  logic [HALF_FLOAT_W-1:0]      mult_float1;
  logic [HALF_FLOAT_W-1:0]      mult_float2;
  logic [HALF_FLOAT_W-1:0]      mult_product;
  logic                         busy;
  logic [15:0]                  op_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_ops  = 0;
  int unsigned cycle    = 0;

  zfh_mult_sched #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT),
    .ID_W    (ID_W)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_float1   (req_float1),
    .req_float2   (req_float2),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_product  (rsp_product),
    .mult_float1  (mult_float1),
    .mult_float2  (mult_float2),
    .mult_product (mult_product),
    .busy         (busy),
    .op_count     (op_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle++;

  // Known half-precision products; anything else returns a quiet NaN.
  function automatic logic [15:0] half_mul_stub(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return 16'h4000;  // 1.0 * 2.0
      32'h4000_4000: return 16'h4400;  // 2.0 * 2.0
      32'h3800_4200: return 16'h3E00;  // 0.5 * 3.0
      32'hC000_3C00: return 16'hC000;  // -2.0 * 1.0
      default:       return 16'h7E00;
    endcase
  endfunction

  assign mult_product = half_mul_stub(mult_float1, mult_float2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(output int g, output int cyc);
    g   = -1;
    cyc = 0;
    #1;
    while (req_ready == '0 && cyc < 20) begin
      @(negedge CLK); #1;
      cyc++;
    end
    if (req_ready == '0) begin
      check("grant_timeout", 0, 1);
    end else begin
      check("ready_onehot", $countones(req_ready), 1);
      g = req_ready[1] ? 1 : 0;
    end
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge CLK); #1;
      cyc++;
    end
    if (!rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  task automatic finish_rsp(input int exp_id, input logic [15:0] exp_prod);
    int cyc;
    wait_rsp(cyc);
    check("rsp_latency", cyc, MUL_LAT + 1);
    check("rsp_id", rsp_id, exp_id);
    check("rsp_product", rsp_product, exp_prod);
    @(negedge CLK); #1;
    exp_ops++;
    check("op_count", op_count, exp_ops);
    check("rsp_valid_drop", rsp_valid, 0);
  endtask

  task automatic apply_reset();
    nRST      = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    nRST    = 1'b1;
    exp_ops = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          g;
    int          cyc;
    int unsigned last_cycle;

    nRST       = 1'b0;
    flush      = 1'b0;
    rsp_ready  = 1'b1;
    req_valid  = '0;
    req_float1 = {16'h3800, 16'h3C00};
    req_float2 = {16'h4200, 16'h4000};

    // Reset state
    @(negedge CLK); #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_product", rsp_product, 0);
    check("rst_mult_float1", mult_float1, 0);
    check("rst_mult_float2", mult_float2, 0);
    check("rst_op_count", op_count, 0);
    check("rst_req_ready", req_ready, 0);
    @(negedge CLK);
    nRST = 1'b1;

    // Single request from requester 0: 1.0 * 2.0
    req_valid = 2'b01;
    wait_grant(g, cyc);
    check("t1_grant_cycle", cyc, 0);
    check("t1_grant_id", g, 0);
    @(posedge CLK); #1;
    req_valid = '0;
    check("t1_mult_float1", mult_float1, 16'h3C00);
    check("t1_mult_float2", mult_float2, 16'h4000);
    check("t1_busy", busy, 1);
    finish_rsp(0, 16'h4000);

    // Both requesters continuously valid: rotation and spacing
    apply_reset();
    req_float1 = {16'h3800, 16'h4000};
    req_float2 = {16'h4200, 16'h4000};
    req_valid  = 2'b11;
    last_cycle = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g, cyc);
      check("rr_order", g, k % 2);
      if (k > 0) check("grant_spacing", cycle - last_cycle, MUL_LAT + 2);
      last_cycle = cycle;
      finish_rsp(g, (g == 1) ? 16'h3E00 : 16'h4400);
    end
    req_valid = '0;

    // Back-pressure in DONE
    rsp_ready          = 1'b0;
    req_float1[31:16]  = 16'hC000;
    req_float2[31:16]  = 16'h3C00;
    req_valid          = 2'b10;
    wait_grant(g, cyc);
    check("t3_grant_id", g, 1);
    @(posedge CLK); #1;
    req_valid = '0;
    wait_rsp(cyc);
    check("t3_rsp_latency", cyc, MUL_LAT + 1);
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); #1;
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_id", rsp_id, 1);
      check("stall_rsp_product", rsp_product, 16'hC000);
      check("stall_req_ready", req_ready, 0);
      check("stall_op_count", op_count, exp_ops);
    end
    rsp_ready = 1'b1;
    #1;
    check("handshake_no_grant", req_ready, 0);
    @(negedge CLK); #1;
    exp_ops++;
    check("release_op_count", op_count, exp_ops);
    check("release_rsp_valid", rsp_valid, 0);
    check("release_grant", req_ready, 2'b01);
    @(posedge CLK); #1;
    req_valid = '0;
    finish_rsp(0, 16'h4400);

    // Flush in EXEC with cnt still nonzero
    req_float1[31:16] = 16'h3800;
    req_float2[31:16] = 16'h4200;
    req_valid         = 2'b11;
    wait_grant(g, cyc);
    check("t4_grant_id", g, 1);
    @(negedge CLK); #1;
    check("t4_busy_exec", busy, 1);
    flush = 1'b1;
    @(negedge CLK); #1;
    check("flush_busy", busy, 0);
    check("flush_rsp_valid", rsp_valid, 0);
    check("flush_blocks_grant", req_ready, 0);
    check("flush_op_count", op_count, exp_ops);
    flush = 1'b0;
    #1;
    check("flush_rr_kept", req_ready, 2'b01);
    @(posedge CLK); #1;
    req_valid = '0;
    finish_rsp(0, 16'h4400);

    // Flush together with rsp_ready in DONE
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    wait_grant(g, cyc);
    check("t5_grant_id", g, 0);
    @(posedge CLK); #1;
    req_valid = '0;
    wait_rsp(cyc);
    check("t5_rsp_valid", rsp_valid, 1);
    flush     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge CLK); #1;
    check("flush_hs_rsp_valid", rsp_valid, 0);
    check("flush_hs_busy", busy, 0);
    check("flush_hs_op_count", op_count, exp_ops);
    flush = 1'b0;

    // Asynchronous reset mid-EXEC
    req_valid = 2'b01;
    wait_grant(g, cyc);
    @(posedge CLK); #3;
    nRST      = 1'b0;
    req_valid = '0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_id", rsp_id, 0);
    check("arst_rsp_product", rsp_product, 0);
    check("arst_mult_float1", mult_float1, 0);
    check("arst_mult_float2", mult_float2, 0);
    check("arst_op_count", op_count, 0);
    check("arst_req_ready", req_ready, 0);
    @(negedge CLK);
    nRST      = 1'b1;
    exp_ops   = 0;
    req_valid = 2'b11;
    wait_grant(g, cyc);
    check("arst_first_grant", g, 0);
    check("arst_grant_cycle", cyc, 0);
    @(posedge CLK); #1;
    req_valid = '0;
    finish_rsp(0, 16'h4400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
